// File: rtl/ram_loader.sv
// ram_loader: upstream feeder for the data/instruction RAM.
// After a start pulse it takes LOAD_LEN bytes from a valid/ready stream and
// writes them to consecutive RAM addresses from 0. While loading it owns the
// RAM write port. Otherwise the CPU-side port is passed straight through.
// Ports:
//   clk, rst              clock, async active-low reset
//   start                 begin a load (honoured in IDLE and DONE only)
//   in_data/in_valid      byte stream in; in_ready = loader accepting
//   cpu_addr/datain/we    CPU-side RAM port
//   ram_addr/datain/we    RAM port out
//   busy, done            load in progress / last load completed
//   checksum              sum of accepted bytes mod 2^N
module ram_loader #(
  parameter int N        = 8,
  parameter int M        = 8,
  parameter int LOAD_LEN = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] cpu_addr,
  input  logic [N-1:0] cpu_datain,
  input  logic         cpu_we,
  output logic [M-1:0] ram_addr,
  output logic [N-1:0] ram_datain,
  output logic         ram_we,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  // Counter is one bit wider than the address so LOAD_LEN = 2**M fits.
  localparam logic [M:0] LAST = (M+1)'(LOAD_LEN - 1);

  state_t       r_state;
  logic [M:0]   r_cnt;
  logic [N-1:0] r_checksum;
  logic         r_done;

  logic w_loading;
  logic w_xfer;

  assign w_loading = (r_state == S_LOAD);
  assign w_xfer    = in_valid & w_loading;

  assign busy     = w_loading;
  assign in_ready = w_loading;
  assign done     = r_done;
  assign checksum = r_checksum;

  // Loader owns the RAM port for the whole LOAD state, so CPU writes are
  // dropped there; the write itself happens on the accepting edge.
  always_comb begin
    ram_addr   = cpu_addr;
    ram_datain = cpu_datain;
    ram_we     = cpu_we;
    if (w_loading) begin
      ram_addr   = r_cnt[M-1:0];
      ram_datain = in_data;
      ram_we     = w_xfer;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_checksum <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_cnt      <= '0;
            r_checksum <= '0;
            r_done     <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_cnt      <= r_cnt + 1'b1;
            r_checksum <= r_checksum + in_data;
            if (r_cnt == LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: a LOAD_LEN=26 instance for the main
// sequences and a LOAD_LEN=256 instance for the full-depth load.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_datain = '0;
  logic       cpu_we = 1'b0;

  logic       in_ready, ram_we, busy, done;
  logic [7:0] ram_addr, ram_datain, checksum;
  logic       in_ready2, ram_we2, busy2, done2;
  logic [7:0] ram_addr2, ram_datain2, checksum2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_loader #(.N(8), .M(8), .LOAD_LEN(26)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cpu_addr(cpu_addr), .cpu_datain(cpu_datain), .cpu_we(cpu_we),
    .ram_addr(ram_addr), .ram_datain(ram_datain), .ram_we(ram_we),
    .busy(busy), .done(done), .checksum(checksum)
  );

  ram_loader #(.N(8), .M(8), .LOAD_LEN(256)) dut256 (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .cpu_addr(cpu_addr), .cpu_datain(cpu_datain), .cpu_we(cpu_we),
    .ram_addr(ram_addr2), .ram_datain(ram_datain2), .ram_we(ram_we2),
    .busy(busy2), .done(done2), .checksum(checksum2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One accepted byte on the 26-word instance; checks the write it produces.
  task automatic xfer(input logic [7:0] d, input logic [7:0] exp_addr);
    in_data  = d;
    in_valid = 1'b1;
    #1;
    chk("xfer_we",   ram_we,     1'b1);
    chk("xfer_addr", ram_addr,   exp_addr);
    chk("xfer_data", ram_datain, d);
    chk("xfer_busy", busy & in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  // Bytes 0x00..0x19; toggle inserts an idle cycle after each byte.
  // The CPU port is driven at 0x80/0xAA throughout and must be ignored.
  task automatic run_load(input bit toggle);
    cpu_addr = 8'h80; cpu_datain = 8'hAA; cpu_we = 1'b1;
    pulse_start();
    for (int k = 0; k < 26; k++) begin
      xfer(8'(k), 8'(k));
      if (toggle && k < 25) begin
        in_data = 8'hEE;
        in_valid = 1'b0;
        #1;
        chk("idle_we", ram_we, 1'b0);
        chk("idle_busy", busy, 1'b1);
        step();
      end
    end
    #1;
    chk("end_done", done, 1'b1);
    chk("end_busy", busy, 1'b0);
    chk("end_ready", in_ready, 1'b0);
    chk("end_csum", checksum, 8'h45);
    // CPU passthrough is back after the load.
    chk("pass_we",   ram_we,     1'b1);
    chk("pass_addr", ram_addr,   8'h80);
    chk("pass_data", ram_datain, 8'hAA);
    cpu_we = 1'b0;
  endtask

  initial begin
    // Reset state and passthrough during reset.
    cpu_addr = 8'h12; cpu_datain = 8'h34; cpu_we = 1'b1;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_csum", checksum, 8'h00);
    chk("rst_pass_addr", ram_addr, 8'h12);
    chk("rst_pass_data", ram_datain, 8'h34);
    chk("rst_pass_we", ram_we, 1'b1);
    cpu_we = 1'b0;
    rst = 1'b1;
    step();

    // in_valid while idle writes nothing.
    in_valid = 1'b1; in_data = 8'h5A;
    #1;
    chk("idle_valid_we", ram_we, 1'b0);
    chk("idle_valid_ready", in_ready, 1'b0);
    step();
    in_valid = 1'b0;

    run_load(1'b0);
    run_load(1'b1);

    // in_valid in DONE is ignored and leaves the checksum alone.
    in_valid = 1'b1; in_data = 8'h33;
    #1;
    chk("done_valid_we", ram_we, 1'b0);
    step();
    in_valid = 1'b0;
    chk("done_csum_hold", checksum, 8'h45);

    // Reset mid-load after 10 transfers: outputs fall with no clock edge.
    pulse_start();
    for (int k = 0; k < 10; k++) xfer(8'(k), 8'(k));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_csum", checksum, 8'h00);
    rst = 1'b1;
    step();

    // Restart at address 0; a start pulse mid-load changes nothing.
    pulse_start();
    xfer(8'h55, 8'h00);
    for (int k = 1; k < 26; k++) begin
      if (k == 5) start = 1'b1;
      xfer(8'(k), 8'(k));
      start = 1'b0;
    end
    chk("s5_done", done, 1'b1);
    chk("s5_csum", checksum, 8'h9A);   // 0x55 + (1+..+25) = 0x19A

    // start in DONE clears done/checksum and restarts at address 0.
    pulse_start();
    chk("restart_done", done, 1'b0);
    chk("restart_busy", busy, 1'b1);
    chk("restart_csum", checksum, 8'h00);
    xfer(8'h07, 8'h00);
    chk("restart_csum1", checksum, 8'h07);

    // Full-depth load on the 256-word instance.
    rst = 1'b0;
    #3;
    rst = 1'b1;
    step();
    pulse_start();
    for (int k = 0; k < 256; k++) begin
      in_data = 8'h01;
      in_valid = 1'b1;
      #1;
      if (k == 0) chk("full_first_addr", ram_addr2, 8'h00);
      if (k == 255) begin
        chk("full_last_addr", ram_addr2, 8'hFF);
        chk("full_last_we", ram_we2, 1'b1);
        chk("full_pre_done", done2, 1'b0);
        chk("full_pre_csum", checksum2, 8'hFF);
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("full_done", done2, 1'b1);
    chk("full_busy", busy2, 1'b0);
    chk("full_csum", checksum2, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
